// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec configuration reset path: sequencer state
// encoding, default timing values and the lock-loss counter width.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD_RST  = 3'd2,
    ST_START     = 3'd3,
    ST_CONFIG    = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RST_HOLD_CYCLES    = 16;
  localparam int DEF_CFG_TIMEOUT_CYCLES = 1000000;
  localparam int LOCK_CNT_W             = 8;

  function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] v);
    if (v == {LOCK_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + LOCK_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/codec_reset_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // shift the asynchronous level through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/codec_reset_sequencer.sv
// Qualifies PLL lock, sequences the downstream reset and configuration start,
// supervises configuration completion and counts lock losses.
module codec_reset_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
  parameter int CFG_TIMEOUT_CYCLES = DEF_CFG_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  cfg_done,
  output logic                  rst_out_n,
  output logic                  cfg_start,
  output logic                  ready,
  output logic                  cfg_error,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int TO_W   = $clog2(CFG_TIMEOUT_CYCLES) + 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(CFG_TIMEOUT_CYCLES - 1);

  logic                  locked_s;
  logic                  lock_fall_s;
  seq_state_e            state_q, state_d, fsm_next_s;
  logic [STAB_W-1:0]     stab_q, stab_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  locked_prev_q, locked_prev_d;
  logic                  rst_out_n_q, rst_out_n_d;
  logic                  cfg_start_q, cfg_start_d;
  logic                  ready_q, ready_d;
  logic                  cfg_error_q, cfg_error_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (locked),
    .q     (locked_s)
  );

  assign lock_fall_s = locked_prev_q & ~locked_s;

  // next state, counters and registered output values
  always_comb begin
    fsm_next_s    = state_q;
    stab_d        = stab_q;
    hold_d        = hold_q;
    to_d          = to_q;
    locked_prev_d = locked_s;

    case (state_q)
      ST_WAIT_LOCK: begin
        stab_d = {STAB_W{1'b0}};
        hold_d = {HOLD_W{1'b0}};
        if (locked_s) begin
          fsm_next_s = ST_STABLE;
        end else begin
          fsm_next_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (locked_s && (stab_q == STAB_LAST)) begin
          fsm_next_s = ST_HOLD_RST;
          stab_d     = {STAB_W{1'b0}};
        end else if (locked_s) begin
          stab_d = stab_q + STAB_W'(1);
        end else begin
          stab_d = stab_q;
        end
      end
      ST_HOLD_RST: begin
        if (hold_q == HOLD_LAST) begin
          fsm_next_s = ST_START;
          hold_d     = {HOLD_W{1'b0}};
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_START: begin
        to_d       = {TO_W{1'b0}};
        fsm_next_s = ST_CONFIG;
      end
      ST_CONFIG: begin
        // completion in the final timeout cycle still counts as success
        if (cfg_done) begin
          fsm_next_s = ST_RUN;
        end else if (to_q == TO_LAST) begin
          fsm_next_s = ST_ERROR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_RUN:   fsm_next_s = ST_RUN;
      ST_ERROR: fsm_next_s = ST_ERROR;
      default:  fsm_next_s = ST_WAIT_LOCK;
    endcase

    state_d     = lock_fall_s ? ST_WAIT_LOCK : fsm_next_s;
    rst_out_n_d = (state_d == ST_START) || (state_d == ST_CONFIG) ||
                  (state_d == ST_RUN)   || (state_d == ST_ERROR);
    cfg_start_d = (state_d == ST_START);
    ready_d     = (state_d == ST_RUN);
    cfg_error_d = (state_d == ST_ERROR);
    lock_cnt_d  = lock_fall_s ? sat_inc(lock_cnt_q) : lock_cnt_q;
  end

  // state, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_WAIT_LOCK;
      stab_q        <= {STAB_W{1'b0}};
      hold_q        <= {HOLD_W{1'b0}};
      to_q          <= {TO_W{1'b0}};
      locked_prev_q <= 1'b0;
      rst_out_n_q   <= 1'b0;
      cfg_start_q   <= 1'b0;
      ready_q       <= 1'b0;
      cfg_error_q   <= 1'b0;
      lock_cnt_q    <= {LOCK_CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      stab_q        <= stab_d;
      hold_q        <= hold_d;
      to_q          <= to_d;
      locked_prev_q <= locked_prev_d;
      rst_out_n_q   <= rst_out_n_d;
      cfg_start_q   <= cfg_start_d;
      ready_q       <= ready_d;
      cfg_error_q   <= cfg_error_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign rst_out_n     = rst_out_n_q;
  assign cfg_start     = cfg_start_q;
  assign ready         = ready_q;
  assign cfg_error     = cfg_error_q;
  assign lock_loss_cnt = lock_cnt_q;

endmodule

// File: tb/tb_codec_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle;
// a negedge monitor pops and compares whenever the output vector changes.
module tb_codec_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       cfg_done;
  logic       rst_out_n;
  logic       cfg_start;
  logic       ready;
  logic       cfg_error;
  logic [7:0] lock_loss_cnt;

  codec_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4),
    .CFG_TIMEOUT_CYCLES (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .cfg_done      (cfg_done),
    .rst_out_n     (rst_out_n),
    .cfg_start     (cfg_start),
    .ready         (ready),
    .cfg_error     (cfg_error),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [11:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec   = 0;
  int          n_miss  = 0;
  int          exp_cnt = 0;
  logic [11:0] obs_s;
  logic [11:0] prev_obs = 12'h000;

  assign obs_s = {rst_out_n, cfg_start, ready, cfg_error, lock_loss_cnt};

  // monitor: every output change must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (obs_s !== prev_obs) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, obs_s);
      end else begin
        e = exp_q.pop_front();
        if ((e.c != cyc) || (e.v !== obs_s)) begin
          n_miss++;
          $display("FAIL out_event cyc=%0d got=%h required cyc=%0d val=%h",
                   cyc, obs_s, e.c, e.v);
        end
      end
      prev_obs = obs_s;
    end
  end

  task automatic push(input int c, input bit rn, input bit st, input bit rd, input bit er);
    exp_t e;
    logic [7:0] cnt8;
    cnt8 = exp_cnt[7:0];
    e.c = c;
    e.v = {rn, st, rd, er, cnt8};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    int a, b, c, d, e, f, g, h, k, j, m;
    rst      = 1'b1;
    locked   = 1'b0;
    cfg_done = 1'b0;
    #1 rst = 1'b0;
    step(3);
    chk("reset_state", obs_s, 12'h000);
    rst = 1'b1;
    step(2);

    // nominal start-up, cfg_done 10 cycles after cfg_start, late cfg_done ignored
    a = cyc;
    locked = 1'b1;
    push(a + 15, 1'b1, 1'b1, 1'b0, 1'b0);
    push(a + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(a + 25);
    cfg_done = 1'b1;
    push(a + 26, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    cfg_done = 1'b0;
    wait_cyc(a + 30);
    cfg_done = 1'b1;
    step(1);
    cfg_done = 1'b0;
    wait_cyc(a + 35);

    // lock loss in RUN
    b = cyc;
    locked = 1'b0;
    exp_cnt++;
    push(b + 3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(b + 8);

    // lock glitch: 5 cycles of locked_s then drop, no release
    c = cyc;
    locked = 1'b1;
    wait_cyc(c + 5);
    locked = 1'b0;
    exp_cnt++;
    push(c + 8, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(c + 10);

    // re-lock with full restart, then configuration timeout
    d = cyc;
    locked = 1'b1;
    push(d + 15, 1'b1, 1'b1, 1'b0, 1'b0);
    push(d + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    push(d + 48, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cyc(d + 60);

    // lock loss clears the error
    e = cyc;
    locked = 1'b0;
    exp_cnt++;
    push(e + 3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(e + 6);

    // cfg_done on the last timeout cycle wins over timeout
    f = cyc;
    locked = 1'b1;
    push(f + 15, 1'b1, 1'b1, 1'b0, 1'b0);
    push(f + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(f + 47);
    cfg_done = 1'b1;
    push(f + 48, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    cfg_done = 1'b0;
    wait_cyc(f + 52);

    g = cyc;
    locked = 1'b0;
    exp_cnt++;
    push(g + 3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(g + 6);

    // lock loss in the same cycle as cfg_done in CONFIG
    h = cyc;
    locked = 1'b1;
    push(h + 15, 1'b1, 1'b1, 1'b0, 1'b0);
    push(h + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(h + 18);
    locked = 1'b0;
    wait_cyc(h + 20);
    cfg_done = 1'b1;
    exp_cnt++;
    push(h + 21, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    cfg_done = 1'b0;
    wait_cyc(h + 26);

    // 300 short lock pulses: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      k = cyc;
      locked = 1'b1;
      if (exp_cnt < 255) begin
        exp_cnt++;
        push(k + 5, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      wait_cyc(k + 2);
      locked = 1'b0;
      wait_cyc(k + 4);
    end
    step(10);
    chk("sat_cnt", obs_s, 12'h0FF);

    // asynchronous reset mid-cycle
    #2;
    exp_cnt = 0;
    push(cyc, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_rst", obs_s, 12'h000);
    step(3);
    rst = 1'b1;
    step(3);

    // reset during HOLD_RST restarts the sequence from scratch
    j = cyc;
    locked = 1'b1;
    wait_cyc(j + 12);
    #2;
    rst = 1'b0;
    #1;
    chk("hold_rst", obs_s, 12'h000);
    wait_cyc(j + 15);
    rst = 1'b1;
    m = cyc;
    push(m + 15, 1'b1, 1'b1, 1'b0, 1'b0);
    push(m + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(m + 31);
    cfg_done = 1'b1;
    push(m + 32, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    cfg_done = 1'b0;
    wait_cyc(m + 40);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
